// File: rtl/spi_controller.sv
// -----------------------------------------------------------------------------
// spi_controller
//
// SPI mode 0, write-only initiator for the 16-bit register-write link.
// One request is taken at a time over a valid/ready handshake. The accepted
// frame {rw, addr[6:0], data[7:0]} is shifted out MSB first on copi, with
// sclk idling low and ncs framing the transfer. There is no CIPO path.
//
// Frame sequence: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE
//   SETUP : ncs low, copi = frame[15], sclk low, CS_SETUP cycles
//   SHIFT : 16 bits, each CLK_DIV cycles low then CLK_DIV cycles high
//   HOLD  : ncs low, sclk low, copi keeps the last bit, CS_HOLD cycles
//   GAP   : ncs high, copi low, not ready, CS_IDLE cycles, done on 1st cycle
//
// Parameters:
//   CLK_DIV  : clk cycles per sclk phase (2..255)
//   CS_SETUP : clk cycles from ncs low to the first sclk low phase (>=1)
//   CS_HOLD  : clk cycles from the last sclk fall to ncs high (>=1)
//   CS_IDLE  : clk cycles ncs stays high before the next accept (>=1)
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   req_valid in   request present
//   req_ready out  controller can accept a request
//   req_rw    in   frame bit 15 (1 = write)
//   req_addr  in   frame bits 14:8
//   req_data  in   frame bits 7:0
//   busy      out  inverse of req_ready
//   done      out  one-cycle pulse when a frame completes (first GAP cycle)
//   sclk      out  SPI clock, idles low
//   copi      out  serial data, changes only when sclk falls
//   ncs       out  chip select, active low, idles high
//
// Every output comes straight from a flop so the pins never glitch.
// -----------------------------------------------------------------------------
module spi_controller #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       copi,
  output logic       ncs
);

  // Illegal parameter values stop elaboration.
  if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("spi_controller: CLK_DIV must be in 2..255");
  end
  if (CS_SETUP < 1) begin : g_bad_cs_setup
    $error("spi_controller: CS_SETUP must be >= 1");
  end
  if (CS_HOLD < 1) begin : g_bad_cs_hold
    $error("spi_controller: CS_HOLD must be >= 1");
  end
  if (CS_IDLE < 1) begin : g_bad_cs_idle
    $error("spi_controller: CS_IDLE must be >= 1");
  end

  // Divider counts CLK_DIV-1 down to 0 within one sclk phase.
  localparam int DIV_W    = $clog2(CLK_DIV);
  // One shared timer serves SETUP, HOLD and GAP; size it for the longest.
  localparam int T_MAX_SH = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int T_MAX    = (T_MAX_SH > CS_IDLE) ? T_MAX_SH : CS_IDLE;
  localparam int TMR_W    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q,   tmr_d;
  logic [DIV_W-1:0]   div_q,   div_d;
  logic               phase_q, phase_d;   // 0 = sclk low phase, 1 = high phase
  logic [4:0]         bit_q,   bit_d;     // index of the bit currently on copi
  // Bits still to be sent after the one already on copi, next bit at [14].
  logic [14:0]        shreg_q, shreg_d;
  logic               ncs_q,   ncs_d;
  logic               sclk_q,  sclk_d;
  logic               copi_q,  copi_d;
  logic               ready_q, ready_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    div_d   = div_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    ncs_d   = ncs_q;
    sclk_d  = sclk_q;
    copi_d  = copi_q;
    ready_d = ready_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          // Latch the whole frame now; request inputs are ignored afterwards.
          state_d = ST_SETUP;
          shreg_d = {req_addr, req_data};
          copi_d  = req_rw;
          ncs_d   = 1'b0;
          sclk_d  = 1'b0;
          ready_d = 1'b0;
          tmr_d   = TMR_W'(CS_SETUP - 1);
        end else begin
          ncs_d   = 1'b1;
          sclk_d  = 1'b0;
          copi_d  = 1'b0;
          ready_d = 1'b1;
        end
      end

      ST_SETUP: begin
        if (tmr_q == {TMR_W{1'b0}}) begin
          state_d = ST_SHIFT;
          div_d   = DIV_W'(CLK_DIV - 1);
          phase_d = 1'b0;
          bit_d   = 5'd0;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end

      ST_SHIFT: begin
        if (div_q != {DIV_W{1'b0}}) begin
          div_d = div_q - DIV_W'(1);
        end else begin
          div_d = DIV_W'(CLK_DIV - 1);
          if (!phase_q) begin
            // End of low phase: raise sclk, copi has been stable a full phase.
            phase_d = 1'b1;
            sclk_d  = 1'b1;
          end else begin
            // End of high phase: sclk falls; copi may only move on this edge.
            phase_d = 1'b0;
            sclk_d  = 1'b0;
            if (bit_q == 5'd15) begin
              // Last bit stays on copi through HOLD.
              state_d = ST_HOLD;
              tmr_d   = TMR_W'(CS_HOLD - 1);
            end else begin
              bit_d   = bit_q + 5'd1;
              copi_d  = shreg_q[14];
              shreg_d = {shreg_q[13:0], 1'b0};
            end
          end
        end
      end

      ST_HOLD: begin
        if (tmr_q == {TMR_W{1'b0}}) begin
          state_d = ST_GAP;
          ncs_d   = 1'b1;
          copi_d  = 1'b0;
          done_d  = 1'b1;
          tmr_d   = TMR_W'(CS_IDLE - 1);
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end

      ST_GAP: begin
        if (tmr_q == {TMR_W{1'b0}}) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end

      default: begin
        // Unreachable encodings fall back to a clean idle.
        state_d = ST_IDLE;
        tmr_d   = {TMR_W{1'b0}};
        div_d   = {DIV_W{1'b0}};
        phase_d = 1'b0;
        bit_d   = 5'd0;
        shreg_d = 15'd0;
        ncs_d   = 1'b1;
        sclk_d  = 1'b0;
        copi_d  = 1'b0;
        ready_d = 1'b1;
      end
    endcase

    busy_d = ~ready_d;
  end

  // State, counters, shift register and output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tmr_q   <= {TMR_W{1'b0}};
      div_q   <= {DIV_W{1'b0}};
      phase_q <= 1'b0;
      bit_q   <= 5'd0;
      shreg_q <= 15'd0;
      ncs_q   <= 1'b1;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      ncs_q   <= ncs_d;
      sclk_q  <= sclk_d;
      copi_q  <= copi_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sclk      = sclk_q;
  assign copi      = copi_q;
  assign ncs       = ncs_q;

endmodule

// File: tb/tb_spi_controller.sv
// -----------------------------------------------------------------------------
// tb_spi_controller
//
// Three spi_controller instances (default timing, CLK_DIV=2 and CLK_DIV=7 with
// all chip-select timings at 1) run the same sequence in parallel: reset,
// a single write, a back-to-back pair, randomized frames with random gaps,
// input isolation during a frame, a mid-frame reset and a write after it.
// Each accepted request pushes {frame, accept cycle} into a per-instance
// queue; a monitor decodes the SPI pins and pops/compares on every nCS rise.
// Expected edge times come from the closed-form timing relations:
//   ncs low at T+1, rise k at T+1+S+(2k+1)D, fall k at T+1+S+(2k+2)D,
//   ncs high and done at E=T+1+S+32D+H, req_ready high at E+I.
// -----------------------------------------------------------------------------
module tb_spi_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  bit fin [3];

  typedef struct packed {
    logic [15:0] frame;
    logic [31:0] t;
  } exp_t;

  task automatic chk(input string name, input int inst, input int got, input int want);
    chk_cnt++;
    if (got == want) pass_cnt++;
    else $display("FAIL %s cfg%0d: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d",
                  name, inst, got, got, want, want, cyc);
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int D = (g == 0) ? 4 : ((g == 1) ? 2 : 7);
    localparam int S = (g == 0) ? 2 : 1;
    localparam int H = (g == 0) ? 2 : 1;
    localparam int I = (g == 0) ? 4 : 1;

    logic       rst_n;
    logic       req_valid, req_ready, req_rw;
    logic [6:0] req_addr;
    logic [7:0] req_data;
    logic       busy, done, sclk, copi, ncs;

    spi_controller #(
      .CLK_DIV (D),
      .CS_SETUP(S),
      .CS_HOLD (H),
      .CS_IDLE (I)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_rw   (req_rw),
      .req_addr (req_addr),
      .req_data (req_data),
      .busy     (busy),
      .done     (done),
      .sclk     (sclk),
      .copi     (copi),
      .ncs      (ncs)
    );

    exp_t exp_q[$];
    int  sent_cnt    = 0;
    int  aborted     = 0;
    int  frames_done = 0;
    int  done_cnt    = 0;
    int  busy_err    = 0;
    int  idle_err    = 0;
    int  copi_err    = 0;
    int  stray_ready = 0;
    int  stray_frame = 0;
    bit  wait_ready  = 1'b0;
    int  ready_due   = 0;

    // Present a frame and hold valid until it is accepted; returns the
    // accept cycle T and leaves valid high one negedge later.
    task automatic send(input logic [15:0] f, output int t);
      bit got;
      got = 1'b0;
      t = -1;
      req_rw    = f[15];
      req_addr  = f[14:8];
      req_data  = f[7:0];
      req_valid = 1'b1;
      for (int w = 0; w < 2000; w++) begin
        if (req_ready === 1'b1) begin
          t = cyc;
          got = 1'b1;
          exp_q.push_back('{frame: f, t: 32'(cyc)});
          sent_cnt++;
          @(negedge clk);
          break;
        end
        @(negedge clk);
      end
      chk("accepted", g, int'(got), 1);
    endtask

    // Monitor: decode pins, pop the scoreboard at each frame end.
    initial begin : mon
      logic        p_ncs, p_sclk, p_copi, p_ready;
      logic [15:0] bits;
      int          nr, nf, fall_c, tm_err, e_t, e_end;
      int          rise_t [16];
      int          fall_t [16];
      bit          in_frame;
      exp_t        e;
      p_ncs = 1'b1; p_sclk = 1'b0; p_copi = 1'b0; p_ready = 1'b1;
      bits = 16'h0; nr = 0; nf = 0; fall_c = 0; in_frame = 1'b0;
      forever begin
        @(negedge clk);
        if (rst_n !== 1'b1) begin
          exp_q.delete();
          in_frame   = 1'b0;
          wait_ready = 1'b0;
          p_ncs = 1'b1; p_sclk = 1'b0; p_copi = 1'b0; p_ready = 1'b1;
        end else begin
          if (busy !== ~req_ready) busy_err++;
          if (ncs === 1'b1 && (sclk !== 1'b0 || copi !== 1'b0)) idle_err++;
          if (copi !== p_copi && !(p_sclk && !sclk) && (p_ncs === ncs)) copi_err++;
          if (done === 1'b1) done_cnt++;

          if (p_ncs && !ncs) begin
            in_frame = 1'b1;
            fall_c = cyc;
            nr = 0; nf = 0; bits = 16'h0;
            if (exp_q.size() == 0) stray_frame++;
            if (req_ready !== 1'b0) stray_ready++;
          end
          if (in_frame && !p_sclk && sclk) begin
            if (nr < 16) begin
              bits = {bits[14:0], copi};
              rise_t[nr] = cyc;
            end
            nr++;
          end
          if (in_frame && p_sclk && !sclk) begin
            if (nf < 16) fall_t[nf] = cyc;
            nf++;
          end

          if (in_frame && !p_ncs && ncs) begin
            in_frame = 1'b0;
            if (exp_q.size() == 0) begin
              stray_frame++;
            end else begin
              e = exp_q.pop_front();
              e_t = int'(e.t);
              e_end = e_t + 1 + S + 32 * D + H;
              chk("frame_bits", g, int'(bits), int'(e.frame));
              chk("rise_count", g, nr, 16);
              chk("fall_count", g, nf, 16);
              chk("ncs_fall", g, fall_c, e_t + 1);
              chk("first_rise", g, rise_t[0], e_t + 1 + S + D);
              chk("last_fall", g, fall_t[15], e_t + 1 + S + 32 * D);
              tm_err = 0;
              for (int k = 0; k < 16; k++) begin
                if (rise_t[k] != e_t + 1 + S + (2 * k + 1) * D) tm_err++;
                if (fall_t[k] != e_t + 1 + S + (2 * k + 2) * D) tm_err++;
              end
              chk("sclk_edge_errs", g, tm_err, 0);
              chk("ncs_rise", g, cyc, e_end);
              chk("done_at_end", g, int'(done), 1);
              frames_done++;
              wait_ready = 1'b1;
              ready_due  = e_end + I;
            end
          end

          if (!p_ready && req_ready) begin
            if (wait_ready) begin
              chk("ready_rise", g, cyc, ready_due);
              wait_ready = 1'b0;
            end else begin
              stray_ready++;
            end
          end
          if (wait_ready && cyc > ready_due + 8) begin
            chk("ready_timeout", g, cyc, ready_due);
            wait_ready = 1'b0;
          end

          p_ncs = ncs; p_sclk = sclk; p_copi = copi; p_ready = req_ready;
        end
      end
    end

    // Stimulus sequence for this configuration.
    initial begin : stim
      int t1, t2, t, gap, tgt;
      logic [15:0] f;
      rst_n = 1'b0;
      for (int r = 0; r < 3; r++) begin
        req_valid = 1'($urandom_range(1, 0));
        req_rw    = 1'($urandom_range(1, 0));
        req_addr  = 7'($urandom);
        req_data  = 8'($urandom);
        @(negedge clk);
        chk("reset_outputs", g, int'({ncs, sclk, copi, req_ready, busy, done}), 6'b100100);
      end
      req_valid = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);

      // Single write, then a back-to-back pair with valid held high.
      send(16'h80F0, t);
      req_valid = 1'b0;
      @(negedge clk);
      send(16'h8480, t1);
      send(16'h82FF, t2);
      req_valid = 1'b0;
      chk("b2b_accept_spacing", g, t2 - t1, 1 + S + 32 * D + H + I);

      // Random frames (including rw=0), random gaps, gap 0 = back-to-back.
      for (int n = 0; n < 10; n++) begin
        f = 16'($urandom);
        send(f, t);
        gap = $urandom_range(3, 0);
        if (gap != 0) begin
          req_valid = 1'b0;
          repeat (gap) @(negedge clk);
        end
      end
      req_valid = 1'b0;

      // Input isolation: scribble on the request port mid-frame.
      f = 16'h8000 | 16'($urandom_range(16'h7FFF, 16'h0001));
      send(f, t);
      req_valid = 1'b0;
      repeat (10) @(negedge clk);
      req_addr  = 7'h00;
      req_data  = 8'h00;
      req_valid = 1'b1;
      repeat (3) @(negedge clk);
      req_valid = 1'b0;

      // Mid-frame reset just after the 8th sclk rise.
      send(16'h8A3C, t);
      req_valid = 1'b0;
      tgt = t + 1 + S + 15 * D;
      while (cyc < tgt) @(negedge clk);
      chk("sclk_high_at_rise8", g, int'(sclk), 1);
      #2 rst_n = 1'b0;
      aborted++;
      #1 chk("midreset_outputs", g, int'({ncs, sclk, copi, req_ready, busy, done}), 6'b100100);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      send(16'h815A, t);
      req_valid = 1'b0;

      for (int w = 0; w < 4000; w++) begin
        if (exp_q.size() == 0 && !wait_ready) break;
        @(negedge clk);
      end
      chk("drained", g, exp_q.size() + int'(wait_ready), 0);
      chk("done_pulses", g, done_cnt, frames_done);
      chk("frames_sent", g, frames_done, sent_cnt - aborted);
      chk("busy_vs_ready", g, busy_err, 0);
      chk("idle_pins", g, idle_err, 0);
      chk("copi_change_rule", g, copi_err, 0);
      chk("stray_ready", g, stray_ready, 0);
      chk("stray_frame", g, stray_frame, 0);
      fin[g] = 1'b1;
    end
  end

  // Wait for all configurations (bounded), then report.
  initial begin : summary
    for (int w = 0; w < 60000; w++) begin
      @(posedge clk);
      if (fin[0] && fin[1] && fin[2]) break;
    end
    chk("all_finished", -1, int'(fin[0] & fin[1] & fin[2]), 1);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
